// File: rtl/adc_calib_pkg.sv
// Shared types and constants for the IDELAY eye-scan block.
// Holds the scan FSM encoding, tap geometry and the eye-centre helper.
package adc_calib_pkg;

  localparam int TAP_W     = 5;
  localparam int TAP_COUNT = 2**TAP_W;

  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_TAP,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT_TAP,
    S_LOAD_CENTER,
    S_REPORT
  } scan_state_t;

  // Centre of a run: start + floor(len/2), kept inside the tap range.
  function automatic logic [TAP_W-1:0] center_tap(input logic [TAP_W-1:0] start,
                                                  input logic [TAP_W:0]   len);
    logic [TAP_W+1:0] sum;
    sum = {2'b00, start} + {1'b0, (len >> 1)};
    if (sum > (TAP_W+2)'(TAP_COUNT - 1)) return TAP_W'(TAP_COUNT - 1);
    return sum[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/idelay_eye_scan_if.sv
// Controller/ISERDES-facing bundle of the eye scanner.
// master = calibration controller side, slave = the scanner.
interface idelay_eye_scan_if #(
  parameter int NUM_LINES    = 12,
  parameter int SERDES_WIDTH = 8
);
  import adc_calib_pkg::*;

  logic                              en_calib_i;
  logic [7:0]                        line_sel_i;
  logic [NUM_LINES*SERDES_WIDTH-1:0] rx_data_i;
  logic [NUM_LINES-1:0]              idelay_ld_o;
  logic [TAP_W-1:0]                  idelay_cntvalue_o;
  logic                              calibration_done_o;
  logic                              calibration_not_done_o;
  logic                              fail_o;
  logic [TAP_W-1:0]                  best_tap_o;

  modport master (
    output en_calib_i, line_sel_i, rx_data_i,
    input  idelay_ld_o, idelay_cntvalue_o, calibration_done_o,
           calibration_not_done_o, fail_o, best_tap_o
  );

  modport slave (
    input  en_calib_i, line_sel_i, rx_data_i,
    output idelay_ld_o, idelay_cntvalue_o, calibration_done_o,
           calibration_not_done_o, fail_o, best_tap_o
  );

endinterface

// File: rtl/eye_run_tracker.sv
// Tracks the current and widest passing run of taps over one sweep.
// Updates once per step; a fail or the last tap closes the open run.
module eye_run_tracker
  import adc_calib_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             step,
  input  logic             pass,
  input  logic             last,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] cur_start;
  logic [TAP_W:0]   cur_len;
  logic [TAP_W-1:0] run_start;
  logic [TAP_W:0]   run_len;
  logic             close_run;

  always_comb begin
    run_start = cur_start;
    run_len   = cur_len;
    close_run = 1'b1;
    if (pass) begin
      if (cur_len == '0) run_start = tap;
      run_len   = cur_len + 1'b1;
      close_run = last;
    end
  end

  // Strict compare keeps the earliest of equally wide runs.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (step) begin
      if (close_run) begin
        if (run_len > best_len) begin
          best_start <= run_start;
          best_len   <= run_len;
        end
        cur_len <= '0;
      end else begin
        cur_start <= run_start;
        cur_len   <= run_len;
      end
    end
  end

endmodule

// File: rtl/idelay_eye_scan.sv
// Sweeps every IDELAY tap of the selected line, parks it at the widest eye centre.
// One attempt takes TAP_COUNT*(SETTLE+SAMPLE+2)+2 cycles; dropping enable aborts.
module idelay_eye_scan
  import adc_calib_pkg::*;
#(
  parameter int                       NUM_LINES     = 12,
  parameter int                       SERDES_WIDTH  = 8,
  parameter logic [SERDES_WIDTH-1:0]  TRAIN_PATTERN = SERDES_WIDTH'(TRAIN_PATTERN_DEF),
  parameter int                       SETTLE_CYCLES = 16,
  parameter int                       SAMPLE_CYCLES = 64,
  parameter int                       MIN_EYE       = 4,
  parameter int                       MAX_SLIPS     = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  idelay_eye_scan_if.slave bus
);

  localparam int LINE_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAP_COUNT - 1);

  scan_state_t             state;
  logic [TAP_W-1:0]        tap;
  logic [LINE_W-1:0]       sel_line;
  logic [CNT_W-1:0]        cnt;
  logic                    pass_all;
  logic [SLIP_W-1:0]       slips;
  logic [7:0]              line_prev;

  logic [SERDES_WIDTH-1:0] words [NUM_LINES];
  logic [LINE_W-1:0]       req_line;
  logic                    word_ok;
  logic                    start_ok;
  logic                    mid_scan;
  logic                    tracker_clear;
  logic                    tracker_step;
  logic                    tracker_last;
  logic [TAP_W-1:0]        best_start;
  logic [TAP_W:0]          best_len;
  logic [TAP_W-1:0]        centre;

  always_comb begin
    for (int n = 0; n < NUM_LINES; n++) begin
      words[n] = bus.rx_data_i[n*SERDES_WIDTH +: SERDES_WIDTH];
    end
  end

  assign req_line      = bus.line_sel_i[LINE_W-1:0];
  assign word_ok       = (words[sel_line] == TRAIN_PATTERN);
  assign start_ok      = bus.en_calib_i && (bus.line_sel_i < 8'(NUM_LINES));
  assign mid_scan      = (state != S_IDLE) && (state != S_REPORT);
  assign tracker_clear = (state == S_IDLE);
  assign tracker_step  = (state == S_NEXT_TAP) && bus.en_calib_i;
  assign tracker_last  = (tap == LAST_TAP);
  assign centre        = center_tap(best_start, best_len);

  eye_run_tracker u_tracker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear      (tracker_clear),
    .step       (tracker_step),
    .pass       (pass_all),
    .last       (tracker_last),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                      <= S_IDLE;
      tap                        <= '0;
      sel_line                   <= '0;
      cnt                        <= '0;
      pass_all                   <= 1'b0;
      slips                      <= '0;
      line_prev                  <= '0;
      bus.idelay_ld_o            <= '0;
      bus.idelay_cntvalue_o      <= '0;
      bus.calibration_done_o     <= 1'b0;
      bus.calibration_not_done_o <= 1'b0;
      bus.fail_o                 <= 1'b0;
      bus.best_tap_o             <= '0;
    end else begin
      bus.idelay_ld_o <= '0;
      line_prev       <= bus.line_sel_i;

      // Losing enable mid-sweep abandons it; the IDELAY keeps its last tap.
      if (mid_scan && !bus.en_calib_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            bus.calibration_done_o     <= 1'b0;
            bus.calibration_not_done_o <= 1'b0;
            if (start_ok) begin
              tap                   <= '0;
              sel_line              <= req_line;
              bus.idelay_ld_o       <= NUM_LINES'(1) << req_line;
              bus.idelay_cntvalue_o <= '0;
              state                 <= S_LOAD_TAP;
            end
          end
          S_LOAD_TAP: begin
            cnt   <= '0;
            state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
              cnt      <= '0;
              pass_all <= 1'b1;
              state    <= S_SAMPLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SAMPLE: begin
            pass_all <= pass_all & word_ok;
            if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) state <= S_NEXT_TAP;
            else                                  cnt   <= cnt + 1'b1;
          end
          S_NEXT_TAP: begin
            if (tracker_last) begin
              state <= S_LOAD_CENTER;
            end else begin
              tap                   <= tap + 1'b1;
              bus.idelay_ld_o       <= NUM_LINES'(1) << sel_line;
              bus.idelay_cntvalue_o <= tap + 1'b1;
              state                 <= S_LOAD_TAP;
            end
          end
          S_LOAD_CENTER: begin
            bus.idelay_ld_o <= NUM_LINES'(1) << sel_line;
            if (best_len >= (TAP_W+1)'(MIN_EYE)) begin
              bus.idelay_cntvalue_o  <= centre;
              bus.best_tap_o         <= centre;
              bus.calibration_done_o <= 1'b1;
              slips                  <= '0;
            end else begin
              bus.idelay_cntvalue_o      <= '0;
              bus.calibration_not_done_o <= 1'b1;
              if (slips < SLIP_W'(MAX_SLIPS))      slips      <= slips + 1'b1;
              if (slips >= SLIP_W'(MAX_SLIPS - 1)) bus.fail_o <= 1'b1;
            end
            state <= S_REPORT;
          end
          S_REPORT: begin
            if (!bus.en_calib_i) begin
              bus.calibration_done_o     <= 1'b0;
              bus.calibration_not_done_o <= 1'b0;
              state                      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end

      if (bus.line_sel_i != line_prev) slips <= '0;
    end
  end

endmodule

// File: tb/tb_idelay_eye_scan.sv
// Randomised bench for idelay_eye_scan: models the IDELAY/ISERDES line and
// predicts every ld strobe and status output from the eye-selection rules.
module tb_idelay_eye_scan;
  import adc_calib_pkg::*;

  localparam int NL        = 12;
  localparam int SW        = 8;
  localparam int S         = 4;
  localparam int N         = 8;
  localparam int MIN_EYE   = 4;
  localparam int MAX_SLIPS = 16;
  localparam int P         = S + N + 2;
  localparam int SCAN      = TAP_COUNT * P + 2;
  localparam logic [7:0] PAT = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idelay_eye_scan_if #(.NUM_LINES(NL), .SERDES_WIDTH(SW)) bus ();

  idelay_eye_scan #(
    .NUM_LINES(NL), .SERDES_WIDTH(SW), .TRAIN_PATTERN(PAT),
    .SETTLE_CYCLES(S), .SAMPLE_CYCLES(N), .MIN_EYE(MIN_EYE), .MAX_SLIPS(MAX_SLIPS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] pass_mask = '0;
  logic [31:0] bad_one   = '0;
  int          bad_off [32];
  int          line_now  = 0;
  int          cur_tap   = 0;
  int          off       = 1000;
  int          exp_status = 0;
  int          exp_best  = 0;
  bit          exp_fail  = 1'b0;
  int          slips_m   = 0;
  int          ld_total  = 0;
  bit          prev_ld   = 1'b0;
  int          ld_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Widest run of passing taps, first one kept on ties; no wrap-around.
  function automatic void eye_model(input logic [31:0] m, output bit ok, output int centre);
    int bl = 0, bs = 0, l = 0, s = 0;
    for (int t = 0; t <= 32; t++) begin
      if (t < 32 && m[t]) begin
        if (l == 0) s = t;
        l++;
      end else begin
        if (l > bl) begin bl = l; bs = s; end
        l = 0;
      end
    end
    ok     = (bl >= MIN_EYE);
    centre = ok ? ((bs + bl / 2 > 31) ? 31 : bs + bl / 2) : 0;
  endfunction

  function automatic logic [31:0] mask_range(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] rand_mask();
    logic [31:0] m = '0;
    int k, st, ln;
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      st = $urandom_range(0, 31);
      ln = $urandom_range(1, 12);
      for (int j = 0; j < ln; j++) if (st + j < 32) m[st + j] = 1'b1;
    end
    return m;
  endfunction

  // Line model: words settle after a load; failing taps show all-bad or one bad word.
  initial forever begin
    logic [NL*SW-1:0] d;
    logic [7:0]       w;
    @(negedge clk);
    if (|bus.idelay_ld_o) begin
      cur_tap = int'(bus.idelay_cntvalue_o);
      off = 0;
    end else begin
      off = off + 1;
    end
    for (int n = 0; n < NL; n++) d[n*SW +: SW] = 8'($urandom);
    if (off < S)                                        w = 8'($urandom);
    else if (pass_mask[cur_tap])                        w = PAT;
    else if (bad_one[cur_tap] && off != bad_off[cur_tap]) w = PAT;
    else                                                w = PAT ^ 8'($urandom_range(1, 255));
    if (line_now < NL) d[line_now*SW +: SW] = w;
    bus.rx_data_i = d;
  end

  // Every-cycle comparison of the DUT against the expected strobes and status.
  initial forever begin
    int e;
    @(posedge clk);
    #2;
    if (|bus.idelay_ld_o) begin
      ld_total++;
      check("ld_single_cycle", 32'(prev_ld), 32'd0);
      if (ld_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ld actual=%0d required=none", bus.idelay_ld_o);
      end else begin
        e = ld_q.pop_front();
        check("ld_onehot", 32'(bus.idelay_ld_o), 32'(1) << line_now);
        check("ld_tap", 32'(bus.idelay_cntvalue_o), 32'(e));
      end
    end
    prev_ld = |bus.idelay_ld_o;
    check("done", 32'(bus.calibration_done_o), 32'(exp_status == 1));
    check("not_done", 32'(bus.calibration_not_done_o), 32'(exp_status == 2));
    check("fail", 32'(bus.fail_o), 32'(exp_fail));
    check("best_tap", 32'(bus.best_tap_o), 32'(exp_best));
  end

  task automatic set_line(input int line);
    if (line != line_now) slips_m = 0;
    line_now = line;
    bus.line_sel_i = 8'(line);
  endtask

  // Full attempt; called and returns on a negedge.
  task automatic do_scan(input int line, input logic [31:0] mask);
    bit ok;
    int c;
    set_line(line);
    pass_mask = mask;
    bad_one   = $urandom & ~mask;
    for (int t = 0; t < 32; t++) bad_off[t] = $urandom_range(S + 2, S + N - 1);
    eye_model(mask, ok, c);
    for (int t = 0; t < 32; t++) ld_q.push_back(t);
    ld_q.push_back(ok ? c : 0);
    bus.en_calib_i = 1'b1;
    repeat (SCAN - 1) @(negedge clk);
    exp_status = ok ? 1 : 2;
    if (ok) begin
      exp_best = c;
      slips_m  = 0;
    end else begin
      slips_m++;
      if (slips_m >= MAX_SLIPS) exp_fail = 1'b1;
    end
    repeat (3) @(negedge clk);
    bus.en_calib_i = 1'b0;
    exp_status = 0;
    @(negedge clk);
    check("ld_queue_drained", 32'(ld_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    int c, ld_before;

    eye_model(mask_range(10, 19), ok, c);
    check("model_single_ok", 32'(ok), 32'd1);
    check("model_single_centre", 32'(c), 32'd15);
    eye_model(mask_range(2, 5) | mask_range(20, 27), ok, c);
    check("model_two_eyes_centre", 32'(c), 32'd24);
    eye_model(mask_range(2, 5) | mask_range(20, 23), ok, c);
    check("model_equal_eyes_centre", 32'(c), 32'd4);
    eye_model(mask_range(8, 10), ok, c);
    check("model_short_eye_ok", 32'(ok), 32'd0);
    eye_model(32'hFFFF_FFFF, ok, c);
    check("model_all_pass_centre", 32'(c), 32'd16);
    check("center_tap_full", 32'(center_tap(5'd0, 6'd32)), 32'd16);

    rst = 1'b1;
    bus.en_calib_i = 1'b0;
    bus.line_sel_i = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_ld", 32'(bus.idelay_ld_o), 32'd0);
    check("rst_cntvalue", 32'(bus.idelay_cntvalue_o), 32'd0);
    check("rst_done", 32'(bus.calibration_done_o), 32'd0);
    check("rst_not_done", 32'(bus.calibration_not_done_o), 32'd0);
    check("rst_fail", 32'(bus.fail_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Out-of-range line: must stay idle.
    set_line(12);
    ld_before = ld_total;
    bus.en_calib_i = 1'b1;
    repeat (40) @(negedge clk);
    bus.en_calib_i = 1'b0;
    @(negedge clk);
    check("ignored_line_no_ld", 32'(ld_total), 32'(ld_before));

    do_scan(0, mask_range(10, 19));
    check("single_eye_best_tap", 32'(bus.best_tap_o), 32'd15);
    do_scan(1, mask_range(2, 5) | mask_range(20, 27));
    do_scan(1, mask_range(2, 5) | mask_range(20, 23));
    do_scan(2, mask_range(8, 10));
    do_scan(2, 32'hFFFF_FFFF);
    check("all_pass_best_tap", 32'(bus.best_tap_o), 32'd16);
    do_scan(2, 32'h0);

    // Abort during tap 7 sampling, then a clean restart.
    set_line(6);
    pass_mask = mask_range(10, 19);
    bad_one   = '0;
    for (int t = 0; t <= 7; t++) ld_q.push_back(t);
    bus.en_calib_i = 1'b1;
    repeat (1 + 7 * P + S + 3) @(negedge clk);
    bus.en_calib_i = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_ld_count", 32'(ld_q.size()), 32'd0);
    check("abort_tap_kept", 32'(bus.idelay_cntvalue_o), 32'd7);
    do_scan(6, mask_range(10, 19));

    for (int i = 0; i < 12; i++) do_scan($urandom_range(0, NL - 1), rand_mask());

    // Slip counting: line change resets the count, fail is sticky.
    for (int i = 0; i < 10; i++) do_scan(4, $urandom & 32'h7777_7777);
    for (int i = 0; i < 15; i++) do_scan(3, $urandom & 32'h7777_7777);
    check("fail_before_16", 32'(bus.fail_o), 32'(exp_fail));
    do_scan(3, 32'h0);
    check("fail_after_16", 32'(bus.fail_o), 32'd1);
    do_scan(4, 32'hFFFF_FFFF);
    check("fail_sticky_line_change", 32'(bus.fail_o), 32'd1);

    rst = 1'b1;
    exp_fail = 1'b0;
    exp_best = 0;
    slips_m  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("fail_cleared_by_rst", 32'(bus.fail_o), 32'd0);
    check("best_cleared_by_rst", 32'(bus.best_tap_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
